// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_ctrl
// Brief    : Buffer load/hold/flush control for a 5-stage pipeline, including
//            load-use stall, branch flush, memory freeze and interrupt entry.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_ctrl #(
  parameter int REG_ADDR_W   = 3,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic                  branch_taken,
  input  logic                  mem_busy,
  input  logic                  intr,
  output logic                  pc_we,
  output logic                  if_id_we,
  output logic                  id_ex_we,
  output logic                  ex_mem_we,
  output logic                  mem_wb_we,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  save_pc,
  output logic                  push_pc,
  output logic                  push_flags,
  output logic                  sel_intr_pc,
  output logic                  intr_ack
);

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] C_CNT_INIT = CNT_W'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_DRAIN      = 3'd1,
    S_PUSH_PC    = 3'd2,
    S_PUSH_FLAGS = 3'd3,
    S_JUMP       = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pending_q, pending_d;

  logic             w_load_use;
  logic             w_enter;
  logic [CNT_W-1:0] w_cnt_dec;

  assign w_load_use = ex_mem_read &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));
  assign w_enter    = (state_q == S_IDLE) && (pending_q || intr) && !mem_busy;
  assign w_cnt_dec  = (cnt_q == '0) ? '0 : cnt_q - 1'b1;

  // The save_pc cycle counts as the first bubble, so DRAIN leaves as soon as
  // the decremented count reaches zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!mem_busy) begin
      case (state_q)
        S_IDLE: begin
          if (w_enter) begin
            state_d = S_DRAIN;
            cnt_d   = C_CNT_INIT;
          end
        end
        S_DRAIN: begin
          cnt_d = w_cnt_dec;
          if (w_cnt_dec == '0) state_d = S_PUSH_PC;
        end
        S_PUSH_PC:    state_d = S_PUSH_FLAGS;
        S_PUSH_FLAGS: state_d = S_JUMP;
        S_JUMP:       state_d = S_IDLE;
        default:      state_d = S_IDLE;
      endcase
    end
  end

  // A request is consumed when its entry starts; anything arriving later in
  // the sequence stays latched and re-enters from IDLE.
  assign pending_d = w_enter ? 1'b0 : (pending_q | intr);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    pc_we       = 1'b0;
    if_id_we    = 1'b0;
    id_ex_we    = 1'b0;
    ex_mem_we   = 1'b0;
    mem_wb_we   = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    save_pc     = 1'b0;
    push_pc     = 1'b0;
    push_flags  = 1'b0;
    sel_intr_pc = 1'b0;
    intr_ack    = 1'b0;
    if (!rst && !mem_busy) begin
      pc_we     = 1'b1;
      if_id_we  = 1'b1;
      id_ex_we  = 1'b1;
      ex_mem_we = 1'b1;
      mem_wb_we = 1'b1;
      case (state_q)
        S_IDLE: begin
          save_pc = w_enter;
          if (branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (w_load_use) begin
            pc_we       = 1'b0;
            if_id_we    = 1'b0;
            id_ex_flush = 1'b1;
          end
        end
        S_DRAIN: begin
          pc_we       = 1'b0;
          if_id_flush = 1'b1;
          if (branch_taken) begin
            id_ex_flush = 1'b1;
            save_pc     = 1'b1;
          end
        end
        S_PUSH_PC: begin
          pc_we       = 1'b0;
          if_id_flush = 1'b1;
          push_pc     = 1'b1;
        end
        S_PUSH_FLAGS: begin
          pc_we       = 1'b0;
          if_id_flush = 1'b1;
          push_flags  = 1'b1;
        end
        S_JUMP: begin
          if_id_flush = 1'b1;
          sel_intr_pc = 1'b1;
          intr_ack    = 1'b1;
        end
        default: begin
          pc_we = 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_ctrl
// Brief    : Directed and random checks of pipeline_ctrl against a timeline
//            model of the interrupt entry sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;
  localparam int AW     = 3;
  localparam int DC     = 3;
  localparam int NDRAIN = (DC > 1) ? DC - 1 : 1;
  localparam int LAST   = NDRAIN + 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1, ex_mem_read = 1'b0, id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
  logic [AW-1:0] ex_rd = '0, id_rs1 = '0, id_rs2 = '0;
  logic          branch_taken = 1'b0, mem_busy = 1'b0, intr = 1'b0;
  logic pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, if_id_flush, id_ex_flush;
  logic save_pc, push_pc, push_flags, sel_intr_pc, intr_ack;

  pipeline_ctrl #(.REG_ADDR_W(AW), .DRAIN_CYCLES(DC)) dut (
    .clk(clk), .rst(rst), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .branch_taken(branch_taken), .mem_busy(mem_busy), .intr(intr),
    .pc_we(pc_we), .if_id_we(if_id_we), .id_ex_we(id_ex_we), .ex_mem_we(ex_mem_we),
    .mem_wb_we(mem_wb_we), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .save_pc(save_pc), .push_pc(push_pc), .push_flags(push_flags),
    .sel_intr_pc(sel_intr_pc), .intr_ack(intr_ack)
  );

  int total = 0;
  int bad   = 0;
  // Model: pos 0 = idle, 1..NDRAIN = drain bubbles, then push_pc, push_flags, jump.
  int pos   = 0;
  bit pend  = 1'b0;

  function automatic logic [11:0] model_out();
    logic pw, fw, dw, xw, mw, ff, df, sp, pp, pf, si, ak, lu;
    {pw, fw, dw, xw, mw, ff, df, sp, pp, pf, si, ak} = '0;
    if (!rst && !mem_busy) begin
      {pw, fw, dw, xw, mw} = 5'b11111;
      lu = ex_mem_read && ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
      if (pos == 0) begin
        sp = pend || intr;
        if (branch_taken) begin ff = 1'b1; df = 1'b1; end
        else if (lu) begin pw = 1'b0; fw = 1'b0; df = 1'b1; end
      end else if (pos <= NDRAIN) begin
        pw = 1'b0; ff = 1'b1;
        if (branch_taken) begin df = 1'b1; sp = 1'b1; end
      end else if (pos == NDRAIN + 1) begin
        pw = 1'b0; ff = 1'b1; pp = 1'b1;
      end else if (pos == NDRAIN + 2) begin
        pw = 1'b0; ff = 1'b1; pf = 1'b1;
      end else begin
        ff = 1'b1; si = 1'b1; ak = 1'b1;
      end
    end
    return {pw, fw, dw, xw, mw, ff, df, sp, pp, pf, si, ak};
  endfunction

  task automatic model_update();
    if (rst) begin
      pos = 0; pend = 1'b0;
    end else if (mem_busy) begin
      pend = pend || intr;
    end else if (pos == 0) begin
      if (pend || intr) begin pos = 1; pend = 1'b0; end
    end else begin
      pend = pend || intr;
      pos  = (pos == LAST) ? 0 : pos + 1;
    end
  endtask

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%03h expected=%03h", tag, obs, exp);
    end
  endtask

  // One clock: sample at negedge against the model (and an optional directed
  // constant), then advance the model on the posedge.
  task automatic step(input string tag, input bit dir = 1'b0, input logic [11:0] dexp = '0);
    logic [11:0] obs;
    @(negedge clk);
    obs = {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, if_id_flush, id_ex_flush,
           save_pc, push_pc, push_flags, sel_intr_pc, intr_ack};
    chk(tag, obs, model_out());
    if (dir) chk({tag, "_dir"}, obs, dexp);
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    step("rst0", 1, 12'h000);
    step("rst1", 1, 12'h000);
    rst = 1'b0;
    step("idle", 1, 12'hF80);

    ex_mem_read = 1'b1; ex_rd = 3'd3; id_rs2 = 3'd3; id_use_rs2 = 1'b1; id_rs1 = 3'd5;
    step("loaduse", 1, 12'h3A0);
    ex_mem_read = 1'b0;
    step("loaduse_next", 1, 12'hF80);
    ex_mem_read = 1'b1; id_use_rs2 = 1'b0; id_rs1 = 3'd3; id_use_rs1 = 1'b0;
    step("nouse_match", 1, 12'hF80);
    id_use_rs2 = 1'b1; id_rs1 = 3'd5; branch_taken = 1'b1;
    step("branch_over_lu", 1, 12'hFE0);
    ex_mem_read = 1'b0; branch_taken = 1'b0; id_use_rs2 = 1'b0;

    intr = 1'b1;
    step("T0_save", 1, 12'hF90);
    intr = 1'b0;
    step("T1_drain", 1, 12'h7C0);
    mem_busy = 1'b1;
    for (int i = 0; i < 4; i++) step("busy_freeze", 1, 12'h000);
    mem_busy = 1'b0;
    step("T2_drain", 1, 12'h7C0);
    intr = 1'b1;
    step("T3_push_pc", 1, 12'h7C8);
    intr = 1'b0;
    step("T4_push_flags", 1, 12'h7C4);
    step("T5_jump", 1, 12'hFC3);
    step("T6_reentry", 1, 12'hF90);
    step("redrain", 1, 12'h7C0);
    rst = 1'b1;
    step("rst_mid", 1, 12'h000);
    rst = 1'b0;
    step("after_rst", 1, 12'hF80);

    for (int n = 0; n < 600; n++) begin
      rst          = ($urandom_range(0, 99) < 2);
      mem_busy     = ($urandom_range(0, 99) < 25);
      intr         = ($urandom_range(0, 99) < 8);
      branch_taken = ($urandom_range(0, 99) < 20);
      ex_mem_read  = ($urandom_range(0, 99) < 40);
      id_use_rs1   = 1'($urandom);
      id_use_rs2   = 1'($urandom);
      ex_rd        = AW'($urandom_range(0, 3));
      id_rs1       = AW'($urandom_range(0, 3));
      id_rs2       = AW'($urandom_range(0, 3));
      step("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
